// File: rtl/cont_bcd_2dig_pkg.sv
// Shared types, constants and load validation for the two-digit BCD counter.
// Optional feature macro: CONT_BCD_DOWN_EN (bidirectional counting).
package cont_bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int BCD_MAX = 9;
   localparam int MOD_DEFAULT = 60;
   localparam bcd_digit_t DIGIT_MAX = bcd_digit_t'(BCD_MAX);

   // A load is accepted only if both digits are decimal and the value is below the modulus.
   function automatic logic load_valid(input bcd_digit_t tens, input bcd_digit_t units,
                                       input int modulus);
      int value;
      value = int'(tens) * 10 + int'(units);
      return (int'(tens) <= BCD_MAX) && (int'(units) <= BCD_MAX) && (value < modulus);
   endfunction

endpackage

// File: rtl/cont_bcd_2dig_if.sv
// Control/data bundle between a counter driver and cont_bcd_2dig.
// Optional feature macro: CONT_BCD_DOWN_EN adds up_dn.
interface cont_bcd_2dig_if;
   import cont_bcd_pkg::*;

   logic       enable;
   logic       clear;
   logic       load;
   bcd_digit_t din_u;
   bcd_digit_t din_d;
`ifdef CONT_BCD_DOWN_EN
   logic       up_dn;
`endif
   bcd_digit_t unidades;
   bcd_digit_t decenas;
   logic       TC;
   logic       ovf;

`ifdef CONT_BCD_DOWN_EN
   modport master (output enable, clear, load, din_u, din_d, up_dn,
                   input  unidades, decenas, TC, ovf);
   modport slave  (input  enable, clear, load, din_u, din_d, up_dn,
                   output unidades, decenas, TC, ovf);
`else
   modport master (output enable, clear, load, din_u, din_d,
                   input  unidades, decenas, TC, ovf);
   modport slave  (input  enable, clear, load, din_u, din_d,
                   output unidades, decenas, TC, ovf);
`endif

endinterface

// File: rtl/cont_bcd_2dig_digit.sv
// Single decade cell: one BCD digit with carry/borrow out, sync clear and load.
// Optional feature macro: CONT_BCD_DOWN_EN adds the up input and decrement path.
module bcd_digit
   import cont_bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
`ifdef CONT_BCD_DOWN_EN
   input  logic       up,
`endif
   input  logic       clear,
   input  logic       load,
   input  bcd_digit_t din,
   output bcd_digit_t digit,
   output logic       carry_out
);

   bcd_digit_t next_digit;

   always_comb begin
      next_digit = digit;
`ifdef CONT_BCD_DOWN_EN
      if (up)
         next_digit = (digit == DIGIT_MAX) ? '0 : digit + 4'd1;
      else
         next_digit = (digit == '0) ? DIGIT_MAX : digit - 4'd1;
`else
      next_digit = (digit == DIGIT_MAX) ? '0 : digit + 4'd1;
`endif
   end

   // Carry (or borrow) fires when this decade rolls over, so the next decade steps too.
`ifdef CONT_BCD_DOWN_EN
   assign carry_out = enable & (up ? (digit == DIGIT_MAX) : (digit == '0));
`else
   assign carry_out = enable & (digit == DIGIT_MAX);
`endif

   always_ff @(posedge clk) begin
      if (reset)
         digit <= '0;
      else if (clear)
         digit <= '0;
      else if (load)
         digit <= din;
      else if (enable)
         digit <= next_digit;
   end

endmodule

// File: rtl/cont_bcd_2dig.sv
// Two-digit BCD modulo-MOD counter (MOD 2..100) with terminal count and sticky wrap flag.
// Optional feature macro: CONT_BCD_DOWN_EN enables up_dn and down counting.
module cont_bcd_2dig
   import cont_bcd_pkg::*;
#(
   parameter int MOD = MOD_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   cont_bcd_2dig_if.slave bus
);

   localparam bcd_digit_t LAST_UNITS = bcd_digit_t'((MOD - 1) % 10);
   localparam bcd_digit_t LAST_TENS  = bcd_digit_t'((MOD - 1) / 10);
   localparam bit FULL_DECADES = (MOD == 100);

   bcd_digit_t units;
   bcd_digit_t tens;
   bcd_digit_t units_din;
   bcd_digit_t tens_din;
   logic       units_carry;
   logic       tens_carry;
   logic       at_last;
   logic       terminal;
   logic       count_en;
   logic       load_ok;
   logic       wrap;
   logic       digit_clear;
   logic       digit_load;
   logic       ovf_q;

   assign at_last  = (units == LAST_UNITS) && (tens == LAST_TENS);
   assign count_en = bus.enable & ~bus.clear & ~bus.load;
   assign load_ok  = bus.load & load_valid(bus.din_d, bus.din_u, MOD);

   // At MOD=100 the natural tens carry is the wrap; otherwise detect MOD-1 explicitly.
`ifdef CONT_BCD_DOWN_EN
   logic dir_up;
   logic at_zero;

   assign dir_up      = bus.up_dn;
   assign at_zero     = (units == '0) && (tens == '0);
   assign terminal    = dir_up ? at_last : at_zero;
   assign wrap        = dir_up ? (FULL_DECADES ? tens_carry : (count_en & at_last))
                               : tens_carry;
   assign digit_clear = bus.clear | (wrap & dir_up);
   assign digit_load  = load_ok | (wrap & ~dir_up);
   assign units_din   = bus.load ? bus.din_u : LAST_UNITS;
   assign tens_din    = bus.load ? bus.din_d : LAST_TENS;
`else
   assign terminal    = at_last;
   assign wrap        = FULL_DECADES ? tens_carry : (count_en & at_last);
   assign digit_clear = bus.clear | wrap;
   assign digit_load  = load_ok;
   assign units_din   = bus.din_u;
   assign tens_din    = bus.din_d;
`endif

   bcd_digit u_units (
      .clk       (clk),
      .reset     (reset),
      .enable    (count_en),
`ifdef CONT_BCD_DOWN_EN
      .up        (dir_up),
`endif
      .clear     (digit_clear),
      .load      (digit_load),
      .din       (units_din),
      .digit     (units),
      .carry_out (units_carry)
   );

   bcd_digit u_tens (
      .clk       (clk),
      .reset     (reset),
      .enable    (units_carry),
`ifdef CONT_BCD_DOWN_EN
      .up        (dir_up),
`endif
      .clear     (digit_clear),
      .load      (digit_load),
      .din       (tens_din),
      .digit     (tens),
      .carry_out (tens_carry)
   );

   // Sticky until reset/clear; loads never touch it.
   always_ff @(posedge clk) begin
      if (reset || bus.clear)
         ovf_q <= 1'b0;
      else if (wrap)
         ovf_q <= 1'b1;
   end

   assign bus.unidades = units;
   assign bus.decenas  = tens;
   assign bus.TC       = bus.enable & terminal;
   assign bus.ovf      = ovf_q;

endmodule

// File: doc/cont_bcd_2dig.md
# cont_bcd_2dig

Two-digit BCD modulo counter that sits directly downstream of the 4-bit binary counter stage and consumes its terminal-count pulse as a count enable. It turns the fast binary tick into a decimal 00..MOD-1 count for display or further cascading. It exposes its own terminal count so that more stages can be chained the same way.

## Interface
- MOD, default 60: count modulus, legal range 2..100; the count runs 00..MOD-1.
- clk  in  1  rising-edge clock, shared with the upstream counter.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count tick; driven by the upstream TC.
- clear  in  1  synchronous clear to 00.
- load  in  1  synchronous parallel load of din_d:din_u.
- din_u  in  4  BCD units value to load.
- din_d  in  4  BCD tens value to load.
- up_dn  in  1  count direction, 1 = up; present only with CONT_BCD_DOWN_EN.
- unidades  out  4  BCD units digit, registered.
- decenas  out  4  BCD tens digit, registered.
- TC  out  1  terminal count, combinational.
- ovf  out  1  sticky wrap flag, registered.

## Operation
- Priority per rising edge: reset > clear > load > enable > hold.
- reset: unidades=0, decenas=0, ovf=0.
- clear: unidades=0, decenas=0, ovf=0.
- load with a valid value: the count takes din_d:din_u. Valid means both digits ≤9 and 10·din_d+din_u < MOD.
- load with an invalid value: ignored; the count and ovf hold.
- ovf is not changed by a load.
- Count up with enable=1:
  - units increment.
  - When units = 9, units go to 0 and tens increment.
  - When the count = MOD-1, the next value is 00 and ovf is set to 1.
- Count down (macro only, enable=1, up_dn=0):
  - units decrement.
  - When units = 0, units go to 9 and tens decrement.
  - When the count = 00, the next value is MOD-1 and ovf is set to 1.
- TC = enable & (count == MOD-1) counting up, or enable & (count == 00) counting down. TC is 0 when enable=0.
- ovf stays at 1 until reset or clear.
- The count is never outside 00..MOD-1, and each digit is always ≤9.

## Timing
- Count latency: the new value appears on the same edge that samples enable=1.
- TC is combinational from enable and the registered count. It is valid in the same cycle as the enable pulse, so a downstream stage cascades with zero added latency.
- ovf rises on the same edge as the wrap to 00 (or to MOD-1 counting down).
- clear or load asserted together with enable: the enable is discarded for that edge and the wrap is not counted.
- reset asserted mid-count: all outputs are 0 after that edge regardless of the other inputs.
- enable held high continuously: the count advances on every edge.

## Configuration
- CONT_BCD_DOWN_EN defined:
  - adds the up_dn port and bidirectional counting.
  - TC and ovf follow the current direction.
  - A direction change takes effect on the next enabled edge.
- CONT_BCD_DOWN_EN undefined:
  - no up_dn port; the counter counts up only.
  - no down-count logic is synthesised.

## Structure
- Package cont_bcd_pkg holds:
  - typedef bcd_digit_t (4-bit);
  - constants BCD_MAX=9 and MOD_DEFAULT=60;
  - a function that checks whether a load value is valid.
- Sub-module bcd_digit is a single decade cell with:
  - inputs: enable/carry-in, direction, clear, load, din;
  - outputs: digit and carry-out.
- bcd_digit is instantiated twice (units, tens).
- Top-level logic holds the MOD terminal detection, the wrap, ovf and TC.

## Test plan
- Reset, then 60 enable pulses with MOD=60: the count steps 00→59. The 60th pulse gives TC=1 in that cycle, the count wraps to 00 and ovf=1.
- Load 4'd3:4'd9 (39), then one enable: the count becomes 40 and the units carry into tens.
- Load 7:2 (72) with MOD=60, then load 1:A: both are ignored and the count holds its previous value.
- clear and enable both high at count 59: the result is 00 with ovf=0 and no wrap counted.
- MOD=24: from 23 with enable=1 the count goes to 00, TC=1 and ovf=1; with enable=0 at 23, TC=0.
- With CONT_BCD_DOWN_EN, up_dn=0 from 00: one enable gives 59 with TC=1, then another gives 58. Reset mid-count then returns all outputs to 0.
